// File: rtl/pipe_ctrl_unit.sv
// Single-clock pipeline sequencer for the 8-bit core: per-stage valid tracking,
// stage/PC enables, flush, HALT/RESTART control and RAW-hazard stall insertion.
// Stage 0=IF, 1=ID, 2..NUM_STAGES-1 = EX..WB. Optional perf counters: PIPE_PERF_CNT_EN.
//
// Ports:
//   clk_i, rst_i        clock (rising edge), asynchronous active-high reset
//   enable_i            global run gate; low freezes all state and zeroes enables
//   resume_i/restart_i  leave HALT / drain pipeline and clear PC
//   halt_req_i          HLT retiring in last stage
//   br_taken_i          redirect retiring in last stage
//   id_rs*_i            ID-stage source registers and their use flags
//   wr_rd_i, wr_en_i    destination reg / write flag of stages 2..N-1 (stage k at slice k-2)
//   stage_en_o          per-stage latch load enables (combinational)
//   stage_valid_o       per-stage valid bits (registered)
//   pc_en_o, pc_load_o, pc_rst_o, flush_o   PC / squash controls (combinational)
//   halted_o, state_o   HALT indication and FSM state (RUN=0, HALT=1, RESTART=2)
//   cyc_cnt_o, stall_cnt_o, retire_cnt_o    perf counters (PIPE_PERF_CNT_EN only)
module pipe_ctrl_unit #(
  parameter int NUM_STAGES = 4,
  parameter int REG_AW     = 3,
  parameter int CNT_W      = 16
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic                             enable_i,
  input  logic                             resume_i,
  input  logic                             restart_i,
  input  logic                             halt_req_i,
  input  logic                             br_taken_i,
  input  logic [REG_AW-1:0]                id_rs1_i,
  input  logic [REG_AW-1:0]                id_rs2_i,
  input  logic                             id_rs1_use_i,
  input  logic                             id_rs2_use_i,
  input  logic [(NUM_STAGES-2)*REG_AW-1:0] wr_rd_i,
  input  logic [NUM_STAGES-3:0]            wr_en_i,
  output logic [NUM_STAGES-1:0]            stage_en_o,
  output logic [NUM_STAGES-1:0]            stage_valid_o,
  output logic                             pc_en_o,
  output logic                             pc_load_o,
  output logic                             pc_rst_o,
  output logic                             flush_o,
  output logic                             halted_o,
  output logic [1:0]                       state_o
`ifdef PIPE_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0]                 cyc_cnt_o,
  output logic [CNT_W-1:0]                 stall_cnt_o,
  output logic [CNT_W-1:0]                 retire_cnt_o
`endif
);

  localparam int N  = NUM_STAGES;
  localparam int NW = NUM_STAGES - 2;

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_HALT    = 2'd1,
    ST_RESTART = 2'd2
  } state_e;

  state_e         state_q, state_d;
  logic [N-1:0]   valid_q, valid_d;
  logic           halted_q;
  logic           rv;
  logic           haz;
  logic           stall;
  logic           retire;

  assign rv = valid_q[N-1];

  // RAW check against every valid writer downstream of ID; no forwarding,
  // so any pending write to a used source stalls IF/ID.
  always_comb begin
    haz = 1'b0;
    for (int k = 2; k < N; k++) begin
      if (valid_q[k] && wr_en_i[k-2]) begin
        if ((id_rs1_use_i && (wr_rd_i[(k-2)*REG_AW +: REG_AW] == id_rs1_i)) ||
            (id_rs2_use_i && (wr_rd_i[(k-2)*REG_AW +: REG_AW] == id_rs2_i))) begin
          haz = 1'b1;
        end
      end
    end
    haz = haz & valid_q[1];
  end

  always_comb begin
    stage_en_o = '0;
    pc_en_o    = 1'b0;
    pc_load_o  = 1'b0;
    pc_rst_o   = 1'b0;
    flush_o    = 1'b0;
    valid_d    = valid_q;
    state_d    = state_q;
    stall      = 1'b0;
    retire     = 1'b0;
    if (enable_i) begin
      case (state_q)
        ST_RUN: begin
          if (restart_i) begin
            pc_rst_o = 1'b1;
            flush_o  = 1'b1;
            valid_d  = '0;
            state_d  = ST_RESTART;
          end else if (halt_req_i && rv) begin
            // HLT still retires even though the last stage latch is not loaded
            flush_o  = 1'b1;
            valid_d  = '0;
            state_d  = ST_HALT;
            retire   = 1'b1;
          end else if (br_taken_i && rv) begin
            pc_load_o  = 1'b1;
            flush_o    = 1'b1;
            stage_en_o = '1;
            valid_d    = '0;
            retire     = 1'b1;
          end else if (haz) begin
            // IF/ID hold, a bubble enters stage 2, downstream keeps draining
            stage_en_o = {{NW{1'b1}}, 2'b00};
            stall      = 1'b1;
            valid_d[2] = 1'b0;
            for (int k = 3; k < N; k++) valid_d[k] = valid_q[k-1];
            retire     = rv;
          end else begin
            stage_en_o = '1;
            pc_en_o    = 1'b1;
            valid_d    = {valid_q[N-2:0], 1'b1};
            retire     = rv;
          end
        end
        ST_HALT: begin
          if (restart_i) begin
            pc_rst_o = 1'b1;
            state_d  = ST_RESTART;
          end else if (resume_i) begin
            state_d = ST_RUN;
          end
        end
        ST_RESTART: begin
          valid_d = '0;
          if (restart_i) pc_rst_o = 1'b1;
          else           state_d  = ST_RUN;
        end
        default: state_d = ST_RUN;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= ST_RUN;
      valid_q  <= '0;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      valid_q  <= valid_d;
      halted_q <= (state_d == ST_HALT);
    end
  end

  assign stage_valid_o = valid_q;
  assign halted_o      = halted_q;
  assign state_o       = state_q;

`ifdef PIPE_PERF_CNT_EN
  logic [CNT_W-1:0] cyc_q, stall_q, retire_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cyc_q    <= '0;
      stall_q  <= '0;
      retire_q <= '0;
    end else if (enable_i) begin
      cyc_q <= cyc_q + 1'b1;
      if (stall)  stall_q  <= stall_q + 1'b1;
      if (retire) retire_q <= retire_q + 1'b1;
    end
  end

  assign cyc_cnt_o    = cyc_q;
  assign stall_cnt_o  = stall_q;
  assign retire_cnt_o = retire_q;
`endif

endmodule

// File: tb/tb_pipe_ctrl_unit.sv
module tb_pipe_ctrl_unit;
  localparam int NS = 4;
  localparam int AW = 3;
  localparam int CW = 4;

  logic            clk = 1'b0;
  logic            rst, enable, resume, restart, halt_req, br_taken;
  logic [AW-1:0]   rs1, rs2;
  logic            rs1_use, rs2_use;
  logic [2*AW-1:0] wr_rd;
  logic [1:0]      wr_en;
  logic [NS-1:0]   stage_en, stage_valid;
  logic            pc_en, pc_load, pc_rst, flush, halted;
  logic [1:0]      state;
`ifdef PIPE_PERF_CNT_EN
  logic [CW-1:0]   cyc_cnt, stall_cnt, retire_cnt;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  pipe_ctrl_unit #(.NUM_STAGES(NS), .REG_AW(AW), .CNT_W(CW)) dut (
    .clk_i(clk), .rst_i(rst), .enable_i(enable), .resume_i(resume),
    .restart_i(restart), .halt_req_i(halt_req), .br_taken_i(br_taken),
    .id_rs1_i(rs1), .id_rs2_i(rs2), .id_rs1_use_i(rs1_use), .id_rs2_use_i(rs2_use),
    .wr_rd_i(wr_rd), .wr_en_i(wr_en),
    .stage_en_o(stage_en), .stage_valid_o(stage_valid), .pc_en_o(pc_en),
    .pc_load_o(pc_load), .pc_rst_o(pc_rst), .flush_o(flush),
    .halted_o(halted), .state_o(state)
`ifdef PIPE_PERF_CNT_EN
    , .cyc_cnt_o(cyc_cnt), .stall_cnt_o(stall_cnt), .retire_cnt_o(retire_cnt)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic clr_ev();
    resume = 0; restart = 0; halt_req = 0; br_taken = 0;
    rs1 = 0; rs2 = 0; rs1_use = 0; rs2_use = 0; wr_rd = '0; wr_en = '0;
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  logic [3:0] fill_exp [4] = '{4'h1, 4'h3, 4'h7, 4'hF};

  initial begin
    clr_ev();
    enable = 1; rst = 1;
    #3;
    chk("rst_state", state, 0);
    chk("rst_valid", stage_valid, 0);
    chk("rst_stage_en", stage_en, 4'hF);
    chk("rst_pc_en", pc_en, 1);
    chk("rst_flush", flush, 0);
    chk("rst_halted", halted, 0);
    tick(); rst = 0;

    // fill
    for (int i = 0; i < 4; i++) begin
      chk("fill_pc_en", pc_en, 1);
      tick();
      chk("fill_valid", stage_valid, fill_exp[i]);
    end

    // hazard: writer of r3 in stage 2
    rs1 = 3; rs1_use = 1; wr_rd = {3'd0, 3'd3}; wr_en = 2'b01;
    #1; chk("haz_stage_en", stage_en, 4'hC); chk("haz_pc_en", pc_en, 0);
    tick(); chk("haz_valid", stage_valid, 4'hB);
    // writer now in stage 3: still stalls
    wr_rd = {3'd3, 3'd0}; wr_en = 2'b10;
    #1; chk("haz2_stage_en", stage_en, 4'hC);
    tick(); chk("haz2_valid", stage_valid, 4'h3);
    // writer retired: no stall
    wr_en = 2'b00;
    #1; chk("hazok_stage_en", stage_en, 4'hF); chk("hazok_pc_en", pc_en, 1);
    tick(); chk("hazok_valid", stage_valid, 4'h7);
    clr_ev();
    tick(); chk("refill_valid", stage_valid, 4'hF);

    // branch
    br_taken = 1;
    #1; chk("br_pc_load", pc_load, 1); chk("br_flush", flush, 1); chk("br_stage_en", stage_en, 4'hF);
    tick(); br_taken = 0;
    chk("br_valid", stage_valid, 0);
    tick(); chk("br_refill", stage_valid, 4'h1);
    repeat (3) tick();
    chk("br_full", stage_valid, 4'hF);

    // halt / resume
    halt_req = 1;
    #1; chk("hlt_stage_en", stage_en, 0); chk("hlt_flush", flush, 1); chk("hlt_pc_en", pc_en, 0);
    tick(); halt_req = 0;
    chk("hlt_state", state, 1); chk("hlt_halted", halted, 1); chk("hlt_valid", stage_valid, 0);
    repeat (10) tick();
    chk("hlt_hold_state", state, 1); chk("hlt_hold_valid", stage_valid, 0);
    chk("hlt_hold_pc_en", pc_en, 0);
    resume = 1;
    #1; chk("res_stage_en", stage_en, 0);
    tick(); resume = 0;
    chk("res_state", state, 0); chk("res_halted", halted, 0);
    #1; chk("res_pc_en", pc_en, 1);
    tick(); chk("res_valid", stage_valid, 4'h1);
    repeat (3) tick();
    chk("res_full", stage_valid, 4'hF);

    // halt + branch + hazard together: halt wins
    halt_req = 1; br_taken = 1; rs1 = 3; rs1_use = 1; wr_rd = {3'd0, 3'd3}; wr_en = 2'b01;
    #1; chk("pri_pc_load", pc_load, 0); chk("pri_flush", flush, 1); chk("pri_stage_en", stage_en, 0);
    tick(); clr_ev();
    chk("pri_state", state, 1);
    // restart + resume in HALT: restart wins
    restart = 1; resume = 1;
    #1; chk("rr_pc_rst", pc_rst, 1);
    tick(); restart = 0; resume = 0;
    chk("rr_state", state, 2);
    #1; chk("rst_cyc_pc_en", pc_en, 0); chk("rst_cyc_stage_en", stage_en, 0);
    tick(); chk("rr_run", state, 0); chk("rr_valid", stage_valid, 0);

    // enable low during a stall
    repeat (3) tick();
    chk("en_fill", stage_valid, 4'h7);
    rs1 = 3; rs1_use = 1; wr_rd = {3'd0, 3'd3}; wr_en = 2'b01;
    #1; chk("en_haz", stage_en, 4'hC);
    enable = 0;
    #1; chk("en0_stage_en", stage_en, 0); chk("en0_pc_en", pc_en, 0);
    chk("en0_flush", flush, 0); chk("en0_pc_load", pc_load, 0); chk("en0_pc_rst", pc_rst, 0);
    tick(); tick();
    chk("en0_valid", stage_valid, 4'h7);
    enable = 1;
    #1; chk("en1_stage_en", stage_en, 4'hC);

    // asynchronous reset mid-run
    clr_ev();
    #2 rst = 1;
    #1; chk("arst_valid", stage_valid, 0); chk("arst_state", state, 0); chk("arst_stage_en", stage_en, 4'hF);
    tick(); rst = 0;

`ifdef PIPE_PERF_CNT_EN
    rst = 1;
    #1; chk("pc_rst_cyc", cyc_cnt, 0);
    tick(); rst = 0;
    repeat (17) tick();
    chk("perf_cyc_wrap", cyc_cnt, 1);
    chk("perf_retire", retire_cnt, 13);
    rs1 = 3; rs1_use = 1; wr_rd = {3'd0, 3'd3}; wr_en = 2'b01;
    tick();
    wr_rd = {3'd3, 3'd0}; wr_en = 2'b10;
    tick(); clr_ev();
    chk("perf_stall", stall_cnt, 2);
    chk("perf_cyc", cyc_cnt, 3);
    #2 rst = 1;
    #1; chk("perf_arst_cyc", cyc_cnt, 0); chk("perf_arst_stall", stall_cnt, 0);
    chk("perf_arst_ret", retire_cnt, 0);
    tick(); rst = 0;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
